// File: rtl/truth_table_sweeper.sv
// Walks every N_IN-bit input vector into a golden and a candidate function, compares them
// and reports pass/fail, mismatch count and lowest failing vector. Define SWEEP_SIG_EN for sig.
module truth_table_sweeper #(
  parameter int N_IN       = 5,
  parameter int SETTLE_CYC = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 golden_out,
  input  logic                 cand_out,
  output logic [N_IN-1:0]      vec,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [N_IN:0]        mismatch_cnt,
  output logic                 first_bad_vld,
  output logic [N_IN-1:0]      first_bad,
  output logic [2**N_IN-1:0]   sig
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] SETTLE_LOAD = CW'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  state_t        state;
  state_t        state_next;
  state_t        run_state;
  logic [CW-1:0] settle_cnt;
  logic          last_vec;
  logic          mismatch;
  logic          launch;
  logic          do_settle;
  logic          do_sample;

  assign last_vec = (vec == {N_IN{1'b1}});
  assign mismatch = golden_out ^ cand_out;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // With no settle time each vector goes straight to SAMPLE.
  always_comb begin
    run_state  = (SETTLE_CYC == 0) ? SAMPLE : SETTLE;
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) state_next = run_state;
        SETTLE:     if (settle_cnt == '0) state_next = SAMPLE;
        SAMPLE:     state_next = last_vec ? DONE : run_state;
        default:    state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    launch    = 1'b0;
    do_settle = 1'b0;
    do_sample = 1'b0;
    if (!abort) begin
      launch    = start && (state == IDLE || state == DONE);
      do_settle = (state == SETTLE);
      do_sample = (state == SAMPLE);
    end
  end

  // Abort keeps vec, counts and first_bad so the partial result stays inspectable.
  always_ff @(posedge clk) begin
    if (reset) begin
      vec           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      mismatch_cnt  <= '0;
      first_bad_vld <= 1'b0;
      first_bad     <= '0;
      settle_cnt    <= '0;
    end else if (abort) begin
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
    end else if (launch) begin
      vec           <= '0;
      busy          <= 1'b1;
      done          <= 1'b0;
      pass          <= 1'b0;
      mismatch_cnt  <= '0;
      first_bad_vld <= 1'b0;
      first_bad     <= '0;
      settle_cnt    <= SETTLE_LOAD;
    end else if (do_settle) begin
      if (settle_cnt != '0) settle_cnt <= settle_cnt - CW'(1);
    end else if (do_sample) begin
      if (mismatch) begin
        mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
        if (!first_bad_vld) begin
          first_bad     <= vec;
          first_bad_vld <= 1'b1;
        end
      end
      if (last_vec) begin
        busy <= 1'b0;
        done <= 1'b1;
        pass <= (mismatch_cnt == '0) && !mismatch;
      end else begin
        vec        <= vec + N_IN'(1);
        settle_cnt <= SETTLE_LOAD;
      end
    end
  end

`ifdef SWEEP_SIG_EN
  always_ff @(posedge clk) begin
    if (reset)          sig <= '0;
    else if (launch)    sig <= '0;
    else if (do_sample) sig[vec] <= cand_out;
  end
`else
  assign sig = '0;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper at default parameters (32 vectors, 1 settle cycle).
// Expected values are hand-computed; sig expectation follows SWEEP_SIG_EN.
module tb_truth_table_sweeper;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic        golden_out;
  logic        cand_out;
  logic [4:0]  vec;
  logic        busy;
  logic        done;
  logic        pass;
  logic [5:0]  mismatch_cnt;
  logic        first_bad_vld;
  logic [4:0]  first_bad;
  logic [31:0] sig;

  logic [1:0]  mode;
  logic        golden_fn;
  int          checks = 0;
  int          failures = 0;

  truth_table_sweeper dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .golden_out(golden_out), .cand_out(cand_out), .vec(vec), .busy(busy),
    .done(done), .pass(pass), .mismatch_cnt(mismatch_cnt),
    .first_bad_vld(first_bad_vld), .first_bad(first_bad), .sig(sig)
  );

  always #5 clk = ~clk;

  // mode 0: identical, 1: flip at vector 13, 2: inverted, 3: both equal to signal e
  always_comb begin
    golden_fn  = (vec[4] & vec[3]) | (vec[2] ^ vec[1]);
    golden_out = golden_fn;
    cand_out   = golden_fn;
    case (mode)
      2'd1: cand_out = golden_fn ^ (vec == 5'd13);
      2'd2: cand_out = ~golden_fn;
      2'd3: begin
        golden_out = vec[0];
        cand_out   = vec[0];
      end
      default: cand_out = golden_fn;
    endcase
  end

  task automatic run_sweep(output int cycles);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cycles = 0;
    while (!done && cycles < 200) begin
      @(posedge clk);
      cycles++;
      @(negedge clk);
    end
    checks++;
    if (cycles >= 200) begin
      failures++;
      $display("[TB] FAIL sweep_timeout: done never rose within %0d cycles", cycles);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({vec, busy, done, pass, mismatch_cnt, first_bad_vld, first_bad} !== 20'd0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got vec=%0d busy=%b done=%b pass=%b cnt=%0d fbv=%b fb=%0d, want all 0",
               vec, busy, done, pass, mismatch_cnt, first_bad_vld, first_bad);
    end
    checks++;
    if (sig !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_sig: got %h want 0", sig);
    end
  endtask

  task automatic test_identical();
    int cyc;
    mode = 2'd0;
    run_sweep(cyc);
    checks++;
    if (cyc !== 64) begin
      failures++;
      $display("[TB] FAIL identical_latency: got %0d want 64", cyc);
    end
    checks++;
    if ({busy, done, pass, first_bad_vld} !== 4'b0110) begin
      failures++;
      $display("[TB] FAIL identical_flags: busy/done/pass/fbv got %b want 0110",
               {busy, done, pass, first_bad_vld});
    end
    checks++;
    if (mismatch_cnt !== 6'd0) begin
      failures++;
      $display("[TB] FAIL identical_cnt: got %0d want 0", mismatch_cnt);
    end
    checks++;
    if (vec !== 5'd31) begin
      failures++;
      $display("[TB] FAIL identical_vec_end: got %0d want 31", vec);
    end
  endtask

  task automatic test_single_mismatch();
    int cyc;
    mode = 2'd1;
    run_sweep(cyc);
    checks++;
    if (mismatch_cnt !== 6'd1) begin
      failures++;
      $display("[TB] FAIL single_cnt: got %0d want 1", mismatch_cnt);
    end
    checks++;
    if (first_bad !== 5'd13 || first_bad_vld !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_first_bad: got vld=%b fb=%0d want vld=1 fb=13", first_bad_vld, first_bad);
    end
    checks++;
    if (pass !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("[TB] FAIL single_pass: got pass=%b done=%b want pass=0 done=1", pass, done);
    end
  endtask

  task automatic test_inverted();
    int cyc;
    mode = 2'd2;
    run_sweep(cyc);
    checks++;
    if (mismatch_cnt !== 6'b100000) begin
      failures++;
      $display("[TB] FAIL inverted_cnt: got %0d want 32", mismatch_cnt);
    end
    checks++;
    if (first_bad !== 5'd0 || first_bad_vld !== 1'b1) begin
      failures++;
      $display("[TB] FAIL inverted_first_bad: got vld=%b fb=%0d want vld=1 fb=0", first_bad_vld, first_bad);
    end
    checks++;
    if (pass !== 1'b0) begin
      failures++;
      $display("[TB] FAIL inverted_pass: got %b want 0", pass);
    end
  endtask

  // Restart straight from DONE must clear the previous sweep's results.
  task automatic test_back_to_back();
    int cyc;
    mode = 2'd0;
    run_sweep(cyc);
    checks++;
    if (cyc !== 64) begin
      failures++;
      $display("[TB] FAIL b2b_latency: got %0d want 64", cyc);
    end
    checks++;
    if (mismatch_cnt !== 6'd0 || first_bad_vld !== 1'b0 || pass !== 1'b1) begin
      failures++;
      $display("[TB] FAIL b2b_cleared: got cnt=%0d fbv=%b pass=%b want 0/0/1", mismatch_cnt, first_bad_vld, pass);
    end
  endtask

  task automatic test_start_abort();
    int cyc;
    mode = 2'd0;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_busy_after_start: got busy=%b done=%b want 1/0", busy, done);
    end
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_flags: got busy=%b done=%b pass=%b want 0/0/0", busy, done, pass);
    end
    checks++;
    if (vec !== 5'd5) begin
      failures++;
      $display("[TB] FAIL abort_vec: got %0d want 5", vec);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || vec !== 5'd5) begin
      failures++;
      $display("[TB] FAIL abort_idle_hold: got busy=%b vec=%0d want 0/5", busy, vec);
    end
    run_sweep(cyc);
    checks++;
    if (cyc !== 64 || pass !== 1'b1) begin
      failures++;
      $display("[TB] FAIL abort_restart: got cycles=%0d pass=%b want 64/1", cyc, pass);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int guard;
    mode = 2'd2;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (vec !== 5'd20 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 200) begin
      failures++;
      $display("[TB] FAIL reset_mid_reach20: vec got %0d want 20", vec);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({vec, busy, done, pass, mismatch_cnt, first_bad_vld, first_bad} !== 20'd0 || sig !== 32'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_outputs: got vec=%0d busy=%b done=%b cnt=%0d fbv=%b sig=%h want all 0",
               vec, busy, done, mismatch_cnt, first_bad_vld, sig);
    end
    repeat (70) @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_mid_no_completion: got done=%b busy=%b want 0/0", done, busy);
    end
    mode = 2'd0;
    run_sweep(cyc);
    checks++;
    if (cyc !== 64 || pass !== 1'b1 || mismatch_cnt !== 6'd0) begin
      failures++;
      $display("[TB] FAIL reset_mid_restart: got cycles=%0d pass=%b cnt=%0d want 64/1/0", cyc, pass, mismatch_cnt);
    end
  endtask

  task automatic test_signature();
    int cyc;
    logic [31:0] want;
`ifdef SWEEP_SIG_EN
    want = 32'hAAAAAAAA;
`else
    want = 32'h0;
`endif
    mode = 2'd3;
    run_sweep(cyc);
    checks++;
    if (sig !== want) begin
      failures++;
      $display("[TB] FAIL signature: got %h want %h", sig, want);
    end
    checks++;
    if (pass !== 1'b1) begin
      failures++;
      $display("[TB] FAIL signature_pass: got %b want 1", pass);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    mode  = 2'd0;
    test_reset();
    test_identical();
    test_single_mismatch();
    test_inverted();
    test_back_to_back();
    test_start_abort();
    test_reset_mid();
    test_signature();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
